// File: rtl/cpu_pkg.sv
// Shared constants and FSM state encoding for the instruction ROM.
package cpu_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2,
        S_CSUM = 2'd3
    } rom_state_e;

endpackage

// File: rtl/rom_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; a word is emitted on
// lane 3 or on the final byte, with any unfilled upper lanes left as zero.
module rom_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_idx;
    logic [31:0] r_shift;
    logic [31:0] w_lane;

    // r_shift only ever holds lanes below r_idx, so OR-ing in the new lane
    // yields the zero-filled partial word directly.
    assign w_lane       = {24'h00_0000, i_byte} << {r_idx, 3'b000};
    assign o_word       = r_shift | w_lane;
    assign o_word_valid = i_accept & ((r_idx == 2'd3) | i_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_accept) begin
            if (o_word_valid) begin
                r_idx   <= '0;
                r_shift <= '0;
            end else begin
                r_idx   <= r_idx + 2'd1;
                r_shift <= o_word;
            end
        end
    end

endmodule

// File: rtl/instruction_rom.sv
// Loader-filled instruction memory with run-enable control for the core.
// Optional image checksum byte: define INSTRUCTION_ROM_CHECKSUM_EN.
module instruction_rom
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    input  logic              load_restart,
    output logic              cpu_en,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count
);

    rom_state_e        r_state;
    rom_state_e        w_next_state;
    logic [ADDR_W:0]   r_word_count;
    logic [31:0]       r_mem [DEPTH];

    logic              w_hs;
    logic              w_asm_accept;
    logic              w_word_valid;
    logic              w_wr_en;
    logic              w_full;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_hit;
    logic              w_unused_addr_lsb;

    assign w_full       = (r_word_count == (ADDR_W + 1)'(DEPTH));
    assign w_hs         = load_valid & load_ready;
    assign w_asm_accept = w_hs & ~load_restart & (r_state == S_LOAD);
    assign w_wr_en      = w_word_valid & ~w_full;

    rom_byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (load_restart),
        .i_accept     (w_asm_accept),
        .i_byte       (load_byte),
        .i_last       (load_last),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef INSTRUCTION_ROM_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       w_csum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (load_restart) begin
            r_csum <= '0;
        end else if (w_asm_accept) begin
            r_csum <= r_csum ^ load_byte;
        end
    end

    assign w_csum_ok = (load_byte == r_csum);
`endif

    always_comb begin
        w_next_state = r_state;
        if (load_restart) begin
            w_next_state = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_word_valid) begin
                        if (w_full) begin
                            w_next_state = S_ERR;
                        end else if (load_last) begin
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
                            w_next_state = S_CSUM;
`else
                            w_next_state = S_RUN;
`endif
                        end
                    end
                end
`ifdef INSTRUCTION_ROM_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        w_next_state = w_csum_ok ? S_RUN : S_ERR;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_word_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (load_restart) begin
                r_word_count <= '0;
            end else if (w_wr_en) begin
                r_word_count <= r_word_count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_word_count[ADDR_W-1:0]] <= w_word;
        end
    end

    // Address bits above the index must be zero to hit, so aliases fetch NOP.
    assign w_rd_idx          = rom_addr[ADDR_W+1:2];
    assign w_unused_addr_lsb = ^rom_addr[1:0];
    assign w_rd_hit          = (r_state == S_RUN)
                             && ((rom_addr >> (ADDR_W + 2)) == 32'd0)
                             && ({1'b0, w_rd_idx} < r_word_count);
    assign rom_data          = w_rd_hit ? r_mem[w_rd_idx] : NOP_WORD;

    assign load_ready = (r_state == S_LOAD) | (r_state == S_CSUM);
    assign cpu_en     = (r_state == S_RUN);
    assign load_error = (r_state == S_ERR);
    assign word_count = r_word_count;

endmodule
